// File: rtl/cnn_layer_mem_checker.sv
// cnn_layer_mem_checker
//   Parametrised model of the CONV layer result memories with a built-in
//   result checker. NUM_BANKS result banks are served on the csel/crd/cwr
//   bus; each bank has a matching expected-data array loaded while IDLE.
//   When the DUT drops busy, every bank is scanned against its expected
//   data, producing per-bank error counts and a pass flag.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   busy                DUT busy flag (starts/ends a run)
//   csel                bank select, 1..NUM_BANKS valid, else no bank
//   cwr/caddr_wr/cdata_wr   write port (IDLE/RUN only)
//   crd/caddr_rd/cdata_rd   read port, registered, 1-cycle latency
//   exp_we/exp_bank/exp_addr/exp_data  expected-data load (IDLE only)
//   bank_hit            per-bank "received at least one write" flags
//   err_cnt             per-bank saturating error counts, bank k at [k*CNT_W +: CNT_W]
//   done, pass          scan complete / scan clean with at least one bank written
module cnn_layer_mem_checker #(
  parameter int unsigned DATA_W    = 20,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned NUM_BANKS = 5,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned TOL       = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       busy,
  input  logic [SEL_W-1:0]           csel,
  input  logic                       cwr,
  input  logic [ADDR_W-1:0]          caddr_wr,
  input  logic [DATA_W-1:0]          cdata_wr,
  input  logic                       crd,
  input  logic [ADDR_W-1:0]          caddr_rd,
  output logic [DATA_W-1:0]          cdata_rd,
  input  logic                       exp_we,
  input  logic [SEL_W-1:0]           exp_bank,
  input  logic [ADDR_W-1:0]          exp_addr,
  input  logic [DATA_W-1:0]          exp_data,
  output logic [NUM_BANKS-1:0]       bank_hit,
  output logic [NUM_BANKS*CNT_W-1:0] err_cnt,
  output logic                       done,
  output logic                       pass
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned TOTAL  = NUM_BANKS * DEPTH;
  localparam int unsigned IDX_W  = ADDR_W + BANK_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SCAN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Storage: data arrays are never cleared, only their flag arrays are.
  logic [DATA_W-1:0] mem_q       [NUM_BANKS][DEPTH];
  logic [DATA_W-1:0] exp_q       [NUM_BANKS][DEPTH];
  logic [DEPTH-1:0]  written_q   [NUM_BANKS];
  logic [DEPTH-1:0]  exp_valid_q [NUM_BANKS];

  logic [CNT_W-1:0]  err_q [NUM_BANKS];
  logic [CNT_W-1:0]  err_d [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_hit_q;
  logic              done_q, pass_q;
  logic [DATA_W-1:0] cdata_rd_q;

  // Scan fetch stage (registered array read) feeding the compare stage.
  logic [IDX_W-1:0]  scan_cnt_q;
  logic              f_vld_q, f_wr_q, f_ev_q;
  logic [BANK_W-1:0] f_bank_q;
  logic [DATA_W-1:0] f_mem_q, f_exp_q;

  // Decoded selects
  logic              csel_ok, exp_ok;
  logic [BANK_W-1:0] csel_bank, exp_bnk, scan_bank;
  logic [ADDR_W-1:0] scan_addr;

  // Control strobes
  logic wr_en, exp_en, rd_en, restart, scan_fetch, scan_last;

  // Compare stage
  logic [DATA_W-1:0] diff;
  logic              miss, any_err_d, pass_d;

  assign csel_ok   = (csel != '0) && (csel <= SEL_W'(NUM_BANKS));
  assign exp_ok    = (exp_bank != '0) && (exp_bank <= SEL_W'(NUM_BANKS));
  assign csel_bank = BANK_W'(csel - SEL_W'(1));
  assign exp_bnk   = BANK_W'(exp_bank - SEL_W'(1));
  assign scan_bank = scan_cnt_q[ADDR_W +: BANK_W];
  assign scan_addr = scan_cnt_q[ADDR_W-1:0];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (busy)      state_d = S_RUN;
      S_RUN:  if (!busy)     state_d = S_SCAN;
      S_SCAN: if (scan_last) state_d = S_DONE;
      S_DONE: if (busy)      state_d = S_RUN;
      default:               state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs / strobes ----------------
  always_comb begin
    wr_en      = 1'b0;
    exp_en     = 1'b0;
    rd_en      = 1'b0;
    restart    = 1'b0;
    scan_fetch = 1'b0;
    scan_last  = 1'b0;
    if (!reset) begin
      wr_en      = cwr && csel_ok && ((state_q == S_IDLE) || (state_q == S_RUN));
      exp_en     = exp_we && exp_ok && (state_q == S_IDLE);
      rd_en      = crd && csel_ok;
      restart    = (state_q == S_DONE) && busy;
      // SCAN spends TOTAL cycles fetching plus one final cycle for the last compare.
      scan_fetch = (state_q == S_SCAN) && (scan_cnt_q <  IDX_W'(TOTAL));
      scan_last  = (state_q == S_SCAN) && (scan_cnt_q == IDX_W'(TOTAL));
    end
  end

  // ---------------- Data arrays ----------------
  always_ff @(posedge clk) begin
    if (wr_en)  mem_q[csel_bank][caddr_wr] <= cdata_wr;
    if (exp_en) exp_q[exp_bnk][exp_addr]   <= exp_data;
  end

  // ---------------- Flag arrays ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        written_q[b]   <= '0;
        exp_valid_q[b] <= '0;
      end
    end else begin
      if (restart) begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) written_q[b] <= '0;
      end
      if (wr_en)  written_q[csel_bank][caddr_wr] <= 1'b1;
      if (exp_en) exp_valid_q[exp_bnk][exp_addr] <= 1'b1;
    end
  end

  // ---------------- Scan fetch stage ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q <= '0;
      f_vld_q    <= 1'b0;
      f_wr_q     <= 1'b0;
      f_ev_q     <= 1'b0;
      f_bank_q   <= '0;
      f_mem_q    <= '0;
      f_exp_q    <= '0;
    end else begin
      scan_cnt_q <= (state_q == S_SCAN) ? scan_cnt_q + IDX_W'(1) : '0;
      f_vld_q    <= scan_fetch;
      if (scan_fetch) begin
        f_bank_q <= scan_bank;
        f_mem_q  <= mem_q[scan_bank][scan_addr];
        f_exp_q  <= exp_q[scan_bank][scan_addr];
        f_wr_q   <= written_q[scan_bank][scan_addr];
        f_ev_q   <= exp_valid_q[scan_bank][scan_addr];
      end
    end
  end

  // ---------------- Compare stage ----------------
  assign diff = (f_mem_q >= f_exp_q) ? (f_mem_q - f_exp_q) : (f_exp_q - f_mem_q);
  assign miss = f_vld_q && f_ev_q && (!f_wr_q || (diff > DATA_W'(TOL)));

  always_comb begin
    any_err_d = 1'b0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      err_d[b] = err_q[b];
      if (restart)
        err_d[b] = '0;
      else if (miss && (f_bank_q == BANK_W'(b)) && (err_q[b] != '1))
        err_d[b] = err_q[b] + CNT_W'(1);
      if (err_d[b] != '0) any_err_d = 1'b1;
    end
  end

  // pass is taken from the counts including the final compare of this edge.
  assign pass_d = !any_err_d && (bank_hit_q != '0);

  // ---------------- Results and read port ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) err_q[b] <= '0;
      bank_hit_q <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      cdata_rd_q <= '0;
    end else begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) err_q[b] <= err_d[b];
      if (restart)    bank_hit_q <= '0;
      else if (wr_en) bank_hit_q[csel_bank] <= 1'b1;
      if (restart) begin
        done_q <= 1'b0;
        pass_q <= 1'b0;
      end else if (scan_last) begin
        done_q <= 1'b1;
        pass_q <= pass_d;
      end
      if (rd_en) cdata_rd_q <= mem_q[csel_bank][caddr_rd];
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_err
    assign err_cnt[g*CNT_W +: CNT_W] = err_q[g];
  end

  assign cdata_rd = cdata_rd_q;
  assign bank_hit = bank_hit_q;
  assign done     = done_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_cnn_layer_mem_checker.sv
// Directed bench: three instances share one stimulus stream and differ in
// TOL (0, 1, 2); the TOL=2 instance also uses 2-bit counters so saturation
// is reachable with 2 banks of 4 words.
module tb_cnn_layer_mem_checker;

  logic        clk;
  logic        reset;
  logic        busy;
  logic [2:0]  csel;
  logic        cwr;
  logic [1:0]  caddr_wr;
  logic [19:0] cdata_wr;
  logic        crd;
  logic [1:0]  caddr_rd;
  logic        exp_we;
  logic [2:0]  exp_bank;
  logic [1:0]  exp_addr;
  logic [19:0] exp_data;

  logic [19:0] rd0, rd1, rd2;
  logic [1:0]  hit0, hit1, hit2;
  logic [31:0] err0, err1;
  logic [3:0]  err2;
  logic        done0, done1, done2;
  logic        pass0, pass1, pass2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  cnn_layer_mem_checker #(
    .DATA_W(20), .ADDR_W(2), .NUM_BANKS(2), .SEL_W(3), .TOL(0), .CNT_W(16)
  ) u_dut0 (
    .clk(clk), .reset(reset), .busy(busy), .csel(csel), .cwr(cwr),
    .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
    .cdata_rd(rd0), .exp_we(exp_we), .exp_bank(exp_bank), .exp_addr(exp_addr),
    .exp_data(exp_data), .bank_hit(hit0), .err_cnt(err0), .done(done0), .pass(pass0)
  );

  cnn_layer_mem_checker #(
    .DATA_W(20), .ADDR_W(2), .NUM_BANKS(2), .SEL_W(3), .TOL(1), .CNT_W(16)
  ) u_dut1 (
    .clk(clk), .reset(reset), .busy(busy), .csel(csel), .cwr(cwr),
    .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
    .cdata_rd(rd1), .exp_we(exp_we), .exp_bank(exp_bank), .exp_addr(exp_addr),
    .exp_data(exp_data), .bank_hit(hit1), .err_cnt(err1), .done(done1), .pass(pass1)
  );

  cnn_layer_mem_checker #(
    .DATA_W(20), .ADDR_W(2), .NUM_BANKS(2), .SEL_W(3), .TOL(2), .CNT_W(2)
  ) u_dut2 (
    .clk(clk), .reset(reset), .busy(busy), .csel(csel), .cwr(cwr),
    .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
    .cdata_rd(rd2), .exp_we(exp_we), .exp_bank(exp_bank), .exp_addr(exp_addr),
    .exp_data(exp_data), .bank_hit(hit2), .err_cnt(err2), .done(done2), .pass(pass2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic load_exp(input logic [2:0] b, input logic [1:0] a, input logic [19:0] d);
    exp_we = 1'b1; exp_bank = b; exp_addr = a; exp_data = d;
    step();
    exp_we = 1'b0; exp_bank = '0;
  endtask

  task automatic wr(input logic [2:0] b, input logic [1:0] a, input logic [19:0] d);
    cwr = 1'b1; csel = b; caddr_wr = a; cdata_wr = d;
    step();
    cwr = 1'b0; csel = '0;
  endtask

  task automatic rd(input logic [2:0] b, input logic [1:0] a);
    crd = 1'b1; csel = b; caddr_rd = a;
    step();
    crd = 1'b0; csel = '0;
  endtask

  task automatic load_exp_bank0();
    load_exp(3'd1, 2'd0, 20'd1);
    load_exp(3'd1, 2'd1, 20'd2);
    load_exp(3'd1, 2'd2, 20'd3);
    load_exp(3'd1, 2'd3, 20'd4);
  endtask

  // busy=1 moves IDLE->RUN, or DONE->RUN clearing the previous results.
  task automatic start_run();
    busy = 1'b1;
    step();
    check_eq("start_done", {31'd0, done0}, 32'd0);
    check_eq("start_err",  err0, 32'd0);
    check_eq("start_hit",  {30'd0, hit0}, 32'd0);
  endtask

  task automatic write_bank0(input logic [19:0] d0, d1, d2, d3);
    wr(3'd1, 2'd0, d0);
    wr(3'd1, 2'd1, d1);
    wr(3'd1, 2'd2, d2);
    wr(3'd1, 2'd3, d3);
  endtask

  // Drops busy (RUN->SCAN) and counts edges until done; optionally toggles
  // busy and issues a bank0 addr2 write while scanning.
  task automatic end_run(input bit toggle, input bit scan_wr);
    int unsigned cycles;
    busy = 1'b0;
    step();
    cycles = 0;
    while (!done0 && cycles < 40) begin
      busy     = toggle && (cycles == 1 || cycles == 3);
      cwr      = scan_wr && (cycles == 1);
      csel     = cwr ? 3'd1 : 3'd0;
      caddr_wr = 2'd2;
      cdata_wr = 20'd99;
      step();
      cycles++;
    end
    busy = 1'b0; cwr = 1'b0; csel = '0;
    check_eq("scan_len", cycles, 32'd9);
    check_eq("done_all", {29'd0, done0, done1, done2}, 32'd7);
  endtask

  initial begin
    reset = 1'b1; busy = 1'b0; csel = '0; cwr = 1'b0; caddr_wr = '0; cdata_wr = '0;
    crd = 1'b0; caddr_rd = '0; exp_we = 1'b0; exp_bank = '0; exp_addr = '0; exp_data = '0;
    step();
    step();
    reset = 1'b0;

    // Reset values
    check_eq("rst_rd",   {12'd0, rd0}, 32'd0);
    check_eq("rst_hit",  {30'd0, hit0}, 32'd0);
    check_eq("rst_err",  err0, 32'd0);
    check_eq("rst_done", {31'd0, done0}, 32'd0);
    check_eq("rst_pass", {31'd0, pass0}, 32'd0);

    // T1: clean run; busy toggles and a write during SCAN must be ignored
    load_exp_bank0();
    start_run();
    write_bank0(20'd1, 20'd2, 20'd3, 20'd4);
    end_run(1'b1, 1'b1);
    check_eq("t1_err0", err0, 32'd0);
    check_eq("t1_err2", {28'd0, err2}, 32'd0);
    check_eq("t1_hit",  {30'd0, hit0}, 32'h1);
    check_eq("t1_pass", {29'd0, pass0, pass1, pass2}, 32'd7);

    // T2: re-armed run with addr2 = 5 against expected 3
    start_run();
    write_bank0(20'd1, 20'd2, 20'd5, 20'd4);
    end_run(1'b0, 1'b0);
    check_eq("t2_err_tol0", err0, 32'h0000_0001);
    check_eq("t2_err_tol1", err1, 32'h0000_0001);
    check_eq("t2_err_tol2", {28'd0, err2}, 32'd0);
    check_eq("t2_pass", {29'd0, pass0, pass1, pass2}, 32'd1);
    check_eq("t2_hit",  {30'd0, hit0}, 32'h1);

    // Saturation: four errors in bank0; 2-bit counter stops at 3
    start_run();
    write_bank0(20'd100, 20'd100, 20'd100, 20'd100);
    end_run(1'b0, 1'b0);
    check_eq("sat_err16", err0, 32'h0000_0004);
    check_eq("sat_err2",  {28'd0, err2}, 32'h3);
    check_eq("sat_pass",  {29'd0, pass0, pass1, pass2}, 32'd0);

    // T3/T5: bank1 missing write; RUN-time exp load and invalid csel writes dropped
    do_reset();
    load_exp_bank0();
    load_exp(3'd2, 2'd0, 20'd7);
    start_run();
    write_bank0(20'd1, 20'd2, 20'd3, 20'd4);
    load_exp(3'd2, 2'd1, 20'd9);
    wr(3'd0, 2'd1, 20'd55);
    wr(3'd7, 2'd1, 20'd55);
    end_run(1'b0, 1'b0);
    check_eq("t3_err",  err0, 32'h0001_0000);
    check_eq("t3_hit",  {30'd0, hit0}, 32'h1);
    check_eq("t3_pass", {31'd0, pass0}, 32'd0);
    rd(3'd1, 2'd1);
    check_eq("t5_b0a1", {12'd0, rd0}, 32'd2);

    // T4: read latency and read-old-data on same-address write
    do_reset();
    wr(3'd2, 2'd3, 20'hABCDE);
    check_eq("t4_hit", {30'd0, hit0}, 32'h2);
    rd(3'd2, 2'd3);
    check_eq("t4_rd", {12'd0, rd0}, 32'h000A_BCDE);
    cwr = 1'b1; crd = 1'b1; csel = 3'd2; caddr_wr = 2'd3; caddr_rd = 2'd3; cdata_wr = 20'h11111;
    step();
    cwr = 1'b0; crd = 1'b0; csel = '0;
    check_eq("t4_rw_old", {12'd0, rd0}, 32'h000A_BCDE);
    rd(3'd2, 2'd3);
    check_eq("t4_rd_new", {12'd0, rd0}, 32'h0001_1111);
    csel = 3'd1; caddr_rd = 2'd0;
    step();
    csel = '0;
    check_eq("t4_hold_nocrd", {12'd0, rd0}, 32'h0001_1111);
    rd(3'd3, 2'd3);
    check_eq("t4_hold_badsel", {12'd0, rd0}, 32'h0001_1111);

    // T6: reset 3 cycles into SCAN, then a clean repeat of the T2 run
    do_reset();
    load_exp_bank0();
    start_run();
    write_bank0(20'd9, 20'd2, 20'd5, 20'd4);
    busy = 1'b0;
    step();
    step();
    step();
    step();
    check_eq("t6_partial_err", err0, 32'h0000_0001);
    do_reset();
    check_eq("t6_done", {31'd0, done0}, 32'd0);
    check_eq("t6_err",  err0, 32'd0);
    check_eq("t6_hit",  {30'd0, hit0}, 32'd0);
    check_eq("t6_pass", {31'd0, pass0}, 32'd0);
    load_exp_bank0();
    start_run();
    write_bank0(20'd1, 20'd2, 20'd5, 20'd4);
    end_run(1'b0, 1'b0);
    check_eq("t6_rerun_err",  err0, 32'h0000_0001);
    check_eq("t6_rerun_pass", {29'd0, pass0, pass1, pass2}, 32'd1);
    check_eq("t6_rerun_hit",  {30'd0, hit0}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
